// File: rtl/adc_scan_controller.sv
// adc_scan_controller: ADC128S022 channel scanner; define ADC_SCAN_REGFILE_EN to add the 8x12 result register file
module adc_scan_controller #(
    parameter int         CLK_DIV      = 25,
    parameter logic [7:0] CHANNEL_MASK = 8'hFF
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    output logic        ADC_CS_N,
    output logic        ADC_SCLK,
    output logic        ADC_SADDR,
    input  logic        ADC_SDAT,
    output logic        result_valid,
    output logic [2:0]  result_channel,
    output logic [11:0] result_data,
    output logic        busy,
    output logic        done,
    input  logic [2:0]  rd_addr,
    output logic [11:0] rd_data
);
    typedef enum logic [1:0] {IDLE, SETUP, XFER, GAP} state_t;

    function automatic logic [3:0] next_ch(input int c);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--)
            if (CHANNEL_MASK[i] && i > c) r = 4'(i);
        return r;
    endfunction

    localparam logic [3:0] FIRST    = next_ch(-1);
    localparam logic       EMPTY    = CHANNEL_MASK == 8'd0;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  half_cnt;
    logic [2:0]  frame_addr, data_ch;
    logic        prime, last, fin;
    logic [11:0] shift;
    logic [15:0] frame_word;
    logic [3:0]  bit_next, nxt;
    logic        div_end, go;

    always_comb begin
        frame_word = {2'b00, frame_addr, 11'd0};
        bit_next   = 4'((half_cnt + 5'd1) >> 1);
        nxt        = next_ch(int'(frame_addr));
        div_end    = div_cnt == DIV_LAST;
        go         = (start && !busy) || (done && continuous && !EMPTY);
    end

    // data_ch is the address sent in the previous frame: the ADC answers one frame late
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            div_cnt        <= '0;
            half_cnt       <= '0;
            frame_addr     <= '0;
            data_ch        <= '0;
            prime          <= 1'b0;
            last           <= 1'b0;
            fin            <= 1'b0;
            shift          <= '0;
            ADC_CS_N       <= 1'b1;
            ADC_SCLK       <= 1'b1;
            ADC_SADDR      <= 1'b0;
            result_valid   <= 1'b0;
            result_channel <= '0;
            result_data    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done         <= 1'b0;
            fin          <= 1'b0;
            result_valid <= fin && !prime;
            if (fin && !prime) begin
                result_channel <= data_ch;
                result_data    <= shift;
            end
            div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (go && EMPTY) begin
                        done <= 1'b1;
                        busy <= 1'b1;
                    end else if (go) begin
                        state      <= SETUP;
                        busy       <= 1'b1;
                        ADC_CS_N   <= 1'b0;
                        frame_addr <= FIRST[2:0];
                        prime      <= 1'b1;
                        last       <= 1'b0;
                    end else if (done) begin
                        busy <= 1'b0;
                    end
                end
                SETUP: if (div_end) begin
                    state     <= XFER;
                    half_cnt  <= '0;
                    ADC_SCLK  <= 1'b0;
                    ADC_SADDR <= frame_word[15];
                end
                XFER: if (div_end) begin
                    half_cnt <= half_cnt + 5'd1;
                    if (!half_cnt[0]) begin
                        ADC_SCLK <= 1'b1;
                        shift    <= {shift[10:0], ADC_SDAT};
                        fin      <= half_cnt == 5'd30;
                    end else if (half_cnt == 5'd31) begin
                        state    <= GAP;
                        ADC_CS_N <= 1'b1;
                    end else begin
                        ADC_SCLK  <= 1'b0;
                        ADC_SADDR <= frame_word[4'd15 - bit_next];
                    end
                end
                GAP: if (div_end) begin
                    if (last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state      <= SETUP;
                        ADC_CS_N   <= 1'b0;
                        prime      <= 1'b0;
                        data_ch    <= frame_addr;
                        frame_addr <= nxt[3] ? FIRST[2:0] : nxt[2:0];
                        last       <= nxt[3];
                    end
                end
            endcase
        end
    end

`ifdef ADC_SCAN_REGFILE_EN
    logic [11:0] regs [8];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (result_valid) begin
            regs[result_channel] <= result_data;
        end
    end

    assign rd_data = regs[rd_addr];
`else
    logic unused_rd;

    assign unused_rd = ^rd_addr;
    assign rd_data   = 12'h000;
`endif
endmodule

// File: tb/tb_adc_scan_controller.sv
// tb_adc_scan_controller: randomized scoreboard bench with an ADC128S022 behavioural model
module tb_adc_scan_controller;
    localparam int         CLK_DIV = 25;
    localparam logic [7:0] MASK    = 8'hA6;
    localparam int         PER     = 20;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, continuous = 1'b0, sdat = 1'b0, start_e = 1'b0;
    logic [2:0]  rd_addr = 3'd0;
    logic        cs_n, sclk, saddr, rv, busy, done;
    logic [2:0]  rch;
    logic [11:0] rdat, rd_data;
    logic        cs_n_e, sclk_e, saddr_e, rv_e, busy_e, done_e;
    logic [2:0]  rch_e;
    logic [11:0] rdat_e, rd_data_e;

    adc_scan_controller #(.CLK_DIV(CLK_DIV), .CHANNEL_MASK(MASK)) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .continuous(continuous),
        .ADC_CS_N(cs_n), .ADC_SCLK(sclk), .ADC_SADDR(saddr), .ADC_SDAT(sdat),
        .result_valid(rv), .result_channel(rch), .result_data(rdat),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    adc_scan_controller #(.CLK_DIV(CLK_DIV), .CHANNEL_MASK(8'h00)) u_empty (
        .CLOCK_50(clk), .reset(reset), .start(start_e), .continuous(1'b0),
        .ADC_CS_N(cs_n_e), .ADC_SCLK(sclk_e), .ADC_SADDR(saddr_e), .ADC_SDAT(1'b0),
        .result_valid(rv_e), .result_channel(rch_e), .result_data(rdat_e),
        .busy(busy_e), .done(done_e), .rd_addr(3'd0), .rd_data(rd_data_e)
    );

    always #10 clk = ~clk;

    typedef struct packed { logic [2:0] ch; logic [11:0] d; } res_t;

    int          compared = 0, mismatched = 0;
    int          scans = 0, dones = 0, adc_b = 0, cs_e_low = 0;
    time         t16 = 0;
    logic [11:0] chval [8];
    logic [11:0] rf_m [8];
    res_t        exp_q [$];
    logic [2:0]  addr_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A scan returns every enabled channel in ascending order; frames address them, then the lowest again.
    function automatic void push_scan();
        res_t e;
        int first = -1;
        for (int c = 0; c < 8; c++) begin
            if (MASK[c]) begin
                if (first < 0) first = c;
                e.ch = 3'(c);
                e.d  = chval[c];
                exp_q.push_back(e);
                addr_q.push_back(3'(c));
            end
        end
        addr_q.push_back(3'(first));
        scans++;
    endfunction

    function automatic void rand_vals();
        for (int c = 0; c < 8; c++) chval[c] = 12'($urandom);
    endfunction

    initial begin : adc_model
        logic        pcs = 1'b1, psk = 1'b1;
        logic [2:0]  a = 3'd0, ladr = 3'd0, ea;
        logic [15:0] w = 16'd0;
        time         tcs = 0, tr = 0;
        forever begin
            @(cs_n or sclk);
            if (cs_n !== pcs) begin
                if (cs_n === 1'b0) begin
                    adc_b = -1;
                    tcs   = $time;
                    w     = {4'h0, chval[ladr]};
                end else if (cs_n === 1'b1 && adc_b == 15) begin
                    chk("frame_expected", 32'(addr_q.size() > 0), 1);
                    if (addr_q.size() > 0) begin
                        ea = addr_q.pop_front();
                        chk("saddr_field", 32'(a), 32'(ea));
                    end
                    ladr = a;
                end
            end
            if (sclk !== psk && cs_n === 1'b0) begin
                if (sclk === 1'b0) begin
                    adc_b++;
                    if (adc_b == 0) chk("setup_time", 32'($time - tcs), CLK_DIV * PER);
                    if (adc_b <= 15) sdat = w[15 - adc_b];
                end else if (sclk === 1'b1) begin
                    if (adc_b > 0) chk("sclk_period", 32'($time - tr), 2 * CLK_DIV * PER);
                    tr = $time;
                    if (adc_b >= 2 && adc_b <= 4) a[4 - adc_b] = saddr;
                    if (adc_b == 15) t16 = $time;
                end
            end
            pcs = cs_n;
            psk = sclk;
        end
    end

    initial begin : monitor
        res_t e;
        logic psaddr = 1'b0, psclk = 1'b1, preset = 1'b1;
        forever begin
            @(negedge clk);
            if (rv === 1'b1) begin
                chk("result_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("result_channel", 32'(rch), 32'(e.ch));
                    chk("result_data", 32'(rdat), 32'(e.d));
                    chk("result_timing", 32'($time - t16), 30);
                    rf_m[e.ch] = e.d;
                end
            end
            if (done === 1'b1) begin
                dones++;
                chk("busy_at_done", 32'(busy), 1);
                chk("results_pending_at_done", 32'(exp_q.size()), 0);
                if (continuous) push_scan();
            end
            if (!reset && !preset && saddr !== psaddr)
                chk("saddr_on_sclk_fall", 32'(psclk && !sclk), 1);
            if (cs_n_e === 1'b0) cs_e_low++;
            psaddr = saddr;
            psclk  = sclk;
            preset = reset;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (dones < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_within_budget", 32'(dones >= target), 1);
    endtask

    task automatic check_regs();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 rd_addr = 3'(i);
            #1;
`ifdef ADC_SCAN_REGFILE_EN
            chk("rd_data", 32'(rd_data), 32'(rf_m[i]));
`else
            chk("rd_data", 32'(rd_data), 0);
`endif
        end
    endtask

    initial begin : stim
        int tgt, n, lows;
        for (int c = 0; c < 8; c++) begin
            chval[c] = 12'd0;
            rf_m[c]  = 12'd0;
        end
        cycles(3);
        #5;
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_sclk", 32'(sclk), 1);
        chk("rst_saddr", 32'(saddr), 0);
        chk("rst_result_valid", 32'(rv), 0);
        chk("rst_result_channel", 32'(rch), 0);
        chk("rst_result_data", 32'(rdat), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        check_regs();

        for (int s = 0; s < 3; s++) begin
            rand_vals();
            tgt = dones + 1;
            push_scan();
            pulse_start();
            @(negedge clk);
            chk("busy_after_start", 32'(busy), 1);
            if (s == 1) begin
                cycles(300);
                pulse_start();
            end
            wait_done(tgt, 6000);
            cycles(3);
            #1;
            chk("busy_idle", 32'(busy), 0);
            chk("cs_idle", 32'(cs_n), 1);
            check_regs();
        end

        rand_vals();
        @(posedge clk);
        #1 continuous = 1'b1;
        tgt = dones + 3;
        push_scan();
        pulse_start();
        wait_done(tgt, 18000);
        cycles(1000);
        #1 continuous = 1'b0;
        wait_done(tgt + 1, 6000);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cs_n !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("idle_after_continuous", 32'(lows), 0);
        check_regs();

        rand_vals();
        push_scan();
        pulse_start();
        cycles(1000);
        n = 0;
        while (!(adc_b == 8 && sclk === 1'b1 && cs_n === 1'b0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_bit8", 32'(n < 5000), 1);
        #3 reset = 1'b1;
        #1;
        chk("abort_cs_n", 32'(cs_n), 1);
        chk("abort_sclk", 32'(sclk), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_saddr", 32'(saddr), 0);
        exp_q.delete();
        addr_q.delete();
        scans--;
        for (int c = 0; c < 8; c++) rf_m[c] = 12'd0;
        repeat (3) begin
            @(negedge clk);
            chk("no_result_in_reset", 32'(rv), 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        check_regs();
        rand_vals();
        tgt = dones + 1;
        push_scan();
        pulse_start();
        wait_done(tgt, 6000);
        cycles(3);
        check_regs();

        @(posedge clk);
        #1 start_e = 1'b1;
        @(negedge clk);
        chk("empty_done_early", 32'(done_e), 0);
        @(posedge clk);
        #1 start_e = 1'b0;
        @(negedge clk);
        chk("empty_done", 32'(done_e), 1);
        chk("empty_busy", 32'(busy_e), 1);
        @(negedge clk);
        chk("empty_done_pulse", 32'(done_e), 0);
        chk("empty_busy_clear", 32'(busy_e), 0);
        chk("empty_no_frame", 32'(cs_e_low), 0);

        cycles(5);
        chk("scan_count", 32'(dones), 32'(scans));
        chk("frames_outstanding", 32'(addr_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
